alu_input_sequencer: RTL and testbench
======================================

Name: alu_input_sequencer

Overview:
- Control-side counterpart of the registered-ALU block. It drives that block's shared data bus and its load_A / load_B / load_Op / updateRes strobes.
- Sequences one user "enter" button over switch data: operand A, then operand B, then opcode, then a result update.
- Sits between board inputs (switches, buttons) and the ALU register wrapper. The top level wires data_in/load_*/updateRes straight across.

Parameters:
- N, 16, data width of switch input and data_in bus.
- DEBOUNCE_CYCLES, 500000, stable cycles required on a button (used only with SEQ_DEBOUNCE_EN).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- data_sw  input  N  switch value, quasi-static
- enter  input  1  raw button, asynchronous to clk
- undo  input  1  raw button, step back one stage
- data_in  output  N  registered data bus to the ALU registers
- load_A  output  1  one-cycle strobe, capture operand A
- load_B  output  1  one-cycle strobe, capture operand B
- load_Op  output  1  one-cycle strobe, capture opcode (ALU uses data_in[1:0])
- updateRes  output  1  one-cycle strobe, capture ALU result and flags
- step  output  2  0=awaiting A, 1=awaiting B, 2=awaiting Op, 3=showing result
- result_valid  output  1  high while in S_SHOW

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high; all state changes on the rising edge of clk.
- Reset values: state S_WAIT_A; data_in=0; all strobes=0; step=0; result_valid=0; synchronizer and edge flops=0.
- Button conditioning:
  - enter and undo each pass through a 2-FF synchronizer, then a rising-edge detector (sync2 & ~sync3).
  - This produces single-cycle pulses enter_pe and undo_pe.
- Pulse latency: enter sampled high at edge e0 → enter_pe valid after e1 → FSM acts at e2.
- States (Moore outputs):
  - S_WAIT_A: enter_pe → S_LOAD_A, data_in<=data_sw. undo_pe ignored.
  - S_LOAD_A: load_A=1 for exactly one cycle → S_WAIT_B.
  - S_WAIT_B: enter_pe → S_LOAD_B, data_in<=data_sw. undo_pe → S_WAIT_A.
  - S_LOAD_B: load_B=1 → S_WAIT_OP.
  - S_WAIT_OP: enter_pe → S_LOAD_OP, data_in<=data_sw. undo_pe → S_WAIT_B.
  - S_LOAD_OP: load_Op=1 → S_CALC.
  - S_CALC: updateRes=1 → S_SHOW. This cycle follows the opcode capture, so the ALU combinational output has settled.
  - S_SHOW: result_valid=1.
    - enter_pe → S_WAIT_A, starting a new operation.
    - undo_pe → S_WAIT_OP, re-entering the opcode only; A and B are kept in the ALU registers.
- Simultaneous enter_pe and undo_pe: enter wins; undo is dropped, not queued.
- Pulses arriving in S_LOAD_*/S_CALC are ignored; a button held high produces only one pulse.
- data_in: changes only on capture edges and holds its value in every other state. Full N bits are passed with no opcode masking.
- Strobe exclusivity: at most one of load_A / load_B / load_Op / updateRes is high in any cycle, and each lasts exactly one cycle.
- step: A states → 0, B states → 1, OP states → 2, S_CALC and S_SHOW → 3.
- Reset mid-sequence (any state, including during a strobe): next cycle is S_WAIT_A with all strobes low and a pending edge discarded.

Optional Feature:
- Macro: SEQ_DEBOUNCE_EN.
- Defined:
  - Each synchronized button feeds a counter. The debounced level toggles only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - The edge detector acts on the debounced level.
  - Latency from a clean press = 2 + DEBOUNCE_CYCLES + 1 cycles to the FSM transition.
- Not defined: no counter; the edge detector acts directly on sync2. Benches run without the macro unless they set DEBOUNCE_CYCLES small, e.g. 4.

Test Plan:
- Full sequence: reset; data_sw=0x0005 enter; 0x0003 enter; 0x0001 enter → load_A with data_in=0x0005, load_B with 0x0003, load_Op with 0x0001. Each strobe is one cycle, in order. updateRes fires the cycle after load_Op, then result_valid=1 and step=3.
- Latency: enter high at edge e0 → load_A high exactly in the cycle after e2; enter held 20 cycles → exactly one load_A.
- Undo: after A=0x00FF loaded, undo in S_WAIT_B → step=0, no strobes; re-enter 0x0011 → load_A with data_in=0x0011. In S_SHOW, undo + enter 0x0002 → only load_Op and updateRes fire.
- Simultaneous enter and undo in S_WAIT_B with data_sw=0x1234 → load_B with 0x1234, step=2.
- Reset asserted in the S_LOAD_B cycle → next cycle load_B=0, step=0, data_in=0; a subsequent enter produces load_A.
- With SEQ_DEBOUNCE_EN and DEBOUNCE_CYCLES=4: enter bouncing 1-0-1 every 2 cycles then stable high → exactly one load_A, 7 cycles after the stable-high edge.

Source files
------------

// File: rtl/alu_input_sequencer.sv
// -----------------------------------------------------------------------------
// alu_input_sequencer
//
// Purpose:
//   Control side of the registered-ALU block. A single "enter" button walks
//   the user through four stages: capture operand A, capture operand B,
//   capture the opcode, then latch the ALU result. An "undo" button steps back
//   one stage. Switch data is copied onto the shared data_in bus on each
//   capture edge, and the matching one-cycle strobe tells the ALU register
//   wrapper which register to load.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   data_sw[N]    switch value (quasi-static)
//   enter         raw button, asynchronous to clk
//   undo          raw button, asynchronous to clk
//   data_in[N]    registered data bus to the ALU registers
//   load_A        one-cycle strobe: capture operand A
//   load_B        one-cycle strobe: capture operand B
//   load_Op       one-cycle strobe: capture opcode (ALU uses data_in[1:0])
//   updateRes     one-cycle strobe: capture ALU result and flags
//   step[2]       0 = awaiting A, 1 = awaiting B, 2 = awaiting Op, 3 = result
//   result_valid  high while the result is being shown
//
// Optional feature:
//   SEQ_DEBOUNCE_EN - when defined, each synchronized button goes through a
//   debounce counter (DEBOUNCE_CYCLES stable cycles) before edge detection.
//   When undefined, edge detection works directly on the synchronizer output.
// -----------------------------------------------------------------------------
module alu_input_sequencer #(
    parameter int N               = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_sw,
    input  logic         enter,
    input  logic         undo,
    output logic [N-1:0] data_in,
    output logic         load_A,
    output logic         load_B,
    output logic         load_Op,
    output logic         updateRes,
    output logic [1:0]   step,
    output logic         result_valid
);

`ifdef SEQ_DEBOUNCE_EN
    localparam bit DEBOUNCE_EN = 1'b1;
`else
    localparam bit DEBOUNCE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_LOAD_A,
        S_WAIT_B,
        S_LOAD_B,
        S_WAIT_OP,
        S_LOAD_OP,
        S_CALC,
        S_SHOW
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning: bit 0 = enter, bit 1 = undo
    // ------------------------------------------------------------------
    localparam int NUM_BTN = 2;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_pe;
    logic               enter_pe;
    logic               undo_pe;

    assign btn_raw  = {undo, enter};
    assign enter_pe = btn_pe[0];
    assign undo_pe  = btn_pe[1];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic sync1_q;
            logic sync2_q;
            logic level;        // level seen by the edge detector
            logic level_prev_q; // previous level (third flop in the raw build)

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_q      <= 1'b0;
                    sync2_q      <= 1'b0;
                    level_prev_q <= 1'b0;
                end else begin
                    sync1_q      <= btn_raw[gi];
                    sync2_q      <= sync1_q;
                    level_prev_q <= level;
                end
            end

            // A zero-cycle debounce degenerates to the raw path.
            if (DEBOUNCE_EN && (DEBOUNCE_CYCLES > 0)) begin : g_db
                localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
                logic [CNT_W-1:0] cnt_q;
                logic             db_q;

                // cnt_q counts consecutive cycles in which the synchronized
                // input disagrees with the debounced level; once it has seen
                // DEBOUNCE_CYCLES of them the level flips on the next edge.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        cnt_q <= '0;
                        db_q  <= 1'b0;
                    end else if (sync2_q == db_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                        cnt_q <= '0;
                        db_q  <= sync2_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                assign level = db_q;
            end else begin : g_raw
                assign level = sync2_q;
            end

            assign btn_pe[gi] = level & ~level_prev_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [N-1:0]   data_in_q, data_in_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_WAIT_A;
            data_in_q <= '0;
        end else begin
            state_q   <= state_d;
            data_in_q <= data_in_d;
        end
    end

    // enter is tested before undo everywhere, so a simultaneous undo is lost.
    always_comb begin
        state_d   = state_q;
        data_in_d = data_in_q;
        case (state_q)
            S_WAIT_A: begin
                if (enter_pe) begin
                    state_d   = S_LOAD_A;
                    data_in_d = data_sw;
                end
            end
            S_LOAD_A: state_d = S_WAIT_B;
            S_WAIT_B: begin
                if (enter_pe) begin
                    state_d   = S_LOAD_B;
                    data_in_d = data_sw;
                end else if (undo_pe) begin
                    state_d = S_WAIT_A;
                end
            end
            S_LOAD_B: state_d = S_WAIT_OP;
            S_WAIT_OP: begin
                if (enter_pe) begin
                    state_d   = S_LOAD_OP;
                    data_in_d = data_sw;
                end else if (undo_pe) begin
                    state_d = S_WAIT_B;
                end
            end
            S_LOAD_OP: state_d = S_CALC;
            // One cycle after the opcode load, so the ALU output has settled.
            S_CALC:    state_d = S_SHOW;
            S_SHOW: begin
                if (enter_pe) begin
                    state_d = S_WAIT_A;
                end else if (undo_pe) begin
                    // A and B stay in the ALU registers; only Op is re-entered.
                    state_d = S_WAIT_OP;
                end
            end
            default: state_d = S_WAIT_A;
        endcase
    end

    // Moore outputs decoded from the state register.
    assign data_in      = data_in_q;
    assign load_A       = (state_q == S_LOAD_A);
    assign load_B       = (state_q == S_LOAD_B);
    assign load_Op      = (state_q == S_LOAD_OP);
    assign updateRes    = (state_q == S_CALC);
    assign result_valid = (state_q == S_SHOW);

    always_comb begin
        step = 2'd3;
        case (state_q)
            S_WAIT_A,  S_LOAD_A:  step = 2'd0;
            S_WAIT_B,  S_LOAD_B:  step = 2'd1;
            S_WAIT_OP, S_LOAD_OP: step = 2'd2;
            default:              step = 2'd3;
        endcase
    end

endmodule

// File: tb/tb_alu_input_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_input_sequencer
//
// Self-checking bench for alu_input_sequencer. Each expected strobe (kind and
// data_in value) is queued when the stimulus that should cause it is driven;
// a negedge monitor pops and compares every strobe the DUT emits. Scenario
// tasks add inline checks on step, result_valid, data_in and timing.
// -----------------------------------------------------------------------------
module tb_alu_input_sequencer;

    localparam int N = 16;

`ifdef SEQ_DEBOUNCE_EN
    localparam int LAT  = 7;   // press edge to FSM transition (debounce = 4)
    localparam int HOLD = 12;
    localparam int GAP  = 14;
`else
    localparam int LAT  = 2;
    localparam int HOLD = 4;
    localparam int GAP  = 6;
`endif

    localparam logic [1:0] K_A   = 2'd0;
    localparam logic [1:0] K_B   = 2'd1;
    localparam logic [1:0] K_OP  = 2'd2;
    localparam logic [1:0] K_RES = 2'd3;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] data_sw;
    logic         enter;
    logic         undo;
    logic [N-1:0] data_in;
    logic         load_A, load_B, load_Op, updateRes;
    logic [1:0]   step;
    logic         result_valid;

    always #5 clk = ~clk;

    alu_input_sequencer #(
        .N               (N),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_sw      (data_sw),
        .enter        (enter),
        .undo         (undo),
        .data_in      (data_in),
        .load_A       (load_A),
        .load_B       (load_B),
        .load_Op      (load_Op),
        .updateRes    (updateRes),
        .step         (step),
        .result_valid (result_valid)
    );

    typedef struct packed {
        logic [1:0]   kind;
        logic [N-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // ---------------- scoreboard monitor ----------------
    logic [3:0] mon_strobes;
    logic [1:0] mon_kind;
    exp_t       mon_e;

    always @(negedge clk) begin
        mon_strobes = {updateRes, load_Op, load_B, load_A};
        if (mon_en && (mon_strobes !== 4'b0000)) begin
            checks++;
            case (mon_strobes)
                4'b0001: mon_kind = K_A;
                4'b0010: mon_kind = K_B;
                4'b0100: mon_kind = K_OP;
                default: mon_kind = K_RES;
            endcase
            if ($countones(mon_strobes) != 1) begin
                errors++;
                $display("FAIL strobe_onehot: strobes=%b required exactly one", mon_strobes);
            end else if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: kind=%0d data_in=%h required no strobe",
                         mon_kind, data_in);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_kind !== mon_e.kind || data_in !== mon_e.data) begin
                    errors++;
                    $display("FAIL strobe_match: kind=%0d data_in=%h required kind=%0d data_in=%h",
                             mon_kind, data_in, mon_e.kind, mon_e.data);
                end else begin
                    $display("strobe kind=%0d data_in=%h step=%0d ok", mon_kind, data_in, step);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_strobe(input logic [1:0] kind, input logic [N-1:0] data);
        sb_q.push_back('{kind: kind, data: data});
    endtask

    task automatic press(input logic [N-1:0] v);
        data_sw = v;
        enter   = 1'b1;
        repeat (HOLD) tick();
        enter = 1'b0;
        repeat (GAP) tick();
    endtask

    task automatic press_undo();
        undo = 1'b1;
        repeat (HOLD) tick();
        undo = 1'b0;
        repeat (GAP) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset   = 1'b1;
        enter   = 1'b0;
        undo    = 1'b0;
        data_sw = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++;
        if (data_in !== '0) begin
            errors++; $display("FAIL reset_data_in: got %h required 0000", data_in);
        end
        checks++;
        if ({load_A, load_B, load_Op, updateRes} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: got %b required 0000",
                               {load_A, load_B, load_Op, updateRes});
        end
        checks++;
        if (step !== 2'd0 || result_valid !== 1'b0) begin
            errors++; $display("FAIL reset_step: step=%0d rv=%b required step=0 rv=0",
                               step, result_valid);
        end
        mon_en = 1'b1;
        $display("reset done");
    endtask

    task automatic test_full_sequence();
        bit found;
        expect_strobe(K_A, 16'h0005);
        press(16'h0005);
        checks++;
        if (step !== 2'd1) begin
            errors++; $display("FAIL seq_step_after_a: got %0d required 1", step);
        end
        expect_strobe(K_B, 16'h0003);
        press(16'h0003);
        checks++;
        if (step !== 2'd2) begin
            errors++; $display("FAIL seq_step_after_b: got %0d required 2", step);
        end
        expect_strobe(K_OP, 16'h0001);
        expect_strobe(K_RES, 16'h0001);
        data_sw = 16'h0001;
        enter   = 1'b1;
        found   = 1'b0;
        for (int i = 0; i < LAT + 6 && !found; i++) begin
            tick();
            if (load_Op === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL seq_load_op_timeout: load_Op not seen required within %0d cycles", LAT + 6);
        end
        tick();
        checks++;
        if (updateRes !== 1'b1) begin
            errors++; $display("FAIL seq_update_res_next: got %b required 1", updateRes);
        end
        tick();
        checks++;
        if (result_valid !== 1'b1 || step !== 2'd3 || data_in !== 16'h0001) begin
            errors++; $display("FAIL seq_show: rv=%b step=%0d data_in=%h required rv=1 step=3 data_in=0001",
                               result_valid, step, data_in);
        end
        repeat (HOLD) tick();
        enter = 1'b0;
        repeat (GAP) tick();
    endtask

    task automatic test_latency();
        int cnt;
        press(16'h0000);   // S_SHOW -> S_WAIT_A, no strobe expected
        checks++;
        if (step !== 2'd0 || result_valid !== 1'b0) begin
            errors++; $display("FAIL lat_new_op: step=%0d rv=%b required step=0 rv=0", step, result_valid);
        end
        expect_strobe(K_A, 16'h00AA);
        data_sw = 16'h00AA;
        enter   = 1'b1;
        cnt     = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == LAT) begin
                checks++;
                if (load_A !== 1'b0) begin
                    errors++; $display("FAIL lat_early: load_A=%b at cycle %0d required 0", load_A, i);
                end
            end
            if (i == LAT + 1) begin
                checks++;
                if (load_A !== 1'b1) begin
                    errors++; $display("FAIL lat_exact: load_A=%b at cycle %0d required 1", load_A, i);
                end
            end
            if (load_A === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 1) begin
            errors++; $display("FAIL lat_held_once: load_A count=%0d required 1", cnt);
        end
        enter = 1'b0;
        repeat (GAP) tick();
    endtask

    task automatic test_undo();
        press_undo();   // S_WAIT_B -> S_WAIT_A
        expect_strobe(K_A, 16'h00FF);
        press(16'h00FF);
        press_undo();
        checks++;
        if (step !== 2'd0 || data_in !== 16'h00FF) begin
            errors++; $display("FAIL undo_to_a: step=%0d data_in=%h required step=0 data_in=00ff", step, data_in);
        end
        expect_strobe(K_A, 16'h0011);
        press(16'h0011);
        checks++;
        if (step !== 2'd1 || data_in !== 16'h0011) begin
            errors++; $display("FAIL undo_reenter_a: step=%0d data_in=%h required step=1 data_in=0011", step, data_in);
        end
        expect_strobe(K_B, 16'h0022);
        press(16'h0022);
        expect_strobe(K_OP, 16'h0003);
        expect_strobe(K_RES, 16'h0003);
        press(16'h0003);
        press_undo();   // S_SHOW -> S_WAIT_OP
        checks++;
        if (step !== 2'd2 || result_valid !== 1'b0 || data_in !== 16'h0003) begin
            errors++; $display("FAIL undo_from_show: step=%0d rv=%b data_in=%h required step=2 rv=0 data_in=0003",
                               step, result_valid, data_in);
        end
        expect_strobe(K_OP, 16'h0002);
        expect_strobe(K_RES, 16'h0002);
        press(16'h0002);
        checks++;
        if (step !== 2'd3 || result_valid !== 1'b1 || data_in !== 16'h0002) begin
            errors++; $display("FAIL undo_new_op: step=%0d rv=%b data_in=%h required step=3 rv=1 data_in=0002",
                               step, result_valid, data_in);
        end
    endtask

    task automatic test_simultaneous();
        press(16'h0000);   // S_SHOW -> S_WAIT_A
        press_undo();      // ignored in S_WAIT_A
        checks++;
        if (step !== 2'd0) begin
            errors++; $display("FAIL undo_in_wait_a: step=%0d required 0", step);
        end
        expect_strobe(K_A, 16'h5555);
        press(16'h5555);
        expect_strobe(K_B, 16'h1234);
        data_sw = 16'h1234;
        enter   = 1'b1;
        undo    = 1'b1;
        repeat (HOLD) tick();
        enter = 1'b0;
        undo  = 1'b0;
        repeat (GAP) tick();
        checks++;
        if (step !== 2'd2 || data_in !== 16'h1234) begin
            errors++; $display("FAIL simul_enter_wins: step=%0d data_in=%h required step=2 data_in=1234", step, data_in);
        end
    endtask

    task automatic test_reset_mid();
        press_undo();   // S_WAIT_OP -> S_WAIT_B
        checks++;
        if (step !== 2'd1) begin
            errors++; $display("FAIL mid_undo_to_b: step=%0d required 1", step);
        end
        expect_strobe(K_B, 16'h0BBB);
        data_sw = 16'h0BBB;
        enter   = 1'b1;
        repeat (LAT + 1) tick();
        checks++;
        if (load_B !== 1'b1) begin
            errors++; $display("FAIL mid_load_b: load_B=%b required 1", load_B);
        end
        reset = 1'b1;
        enter = 1'b0;
        tick();
        checks++;
        if (load_B !== 1'b0 || step !== 2'd0 || data_in !== '0 || result_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset: load_B=%b step=%0d data_in=%h rv=%b required 0 0 0000 0",
                               load_B, step, data_in, result_valid);
        end
        reset = 1'b0;
        repeat (GAP) tick();
        expect_strobe(K_A, 16'h0077);
        press(16'h0077);
        checks++;
        if (step !== 2'd1 || data_in !== 16'h0077) begin
            errors++; $display("FAIL mid_after_reset: step=%0d data_in=%h required step=1 data_in=0077", step, data_in);
        end
    endtask

`ifdef SEQ_DEBOUNCE_EN
    task automatic test_bounce();
        int cnt;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        expect_strobe(K_A, 16'h0042);
        data_sw = 16'h0042;
        for (int b = 0; b < 2; b++) begin
            enter = 1'b1; repeat (2) tick();
            enter = 1'b0; repeat (2) tick();
        end
        enter = 1'b1;
        cnt   = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == LAT + 1) begin
                checks++;
                if (load_A !== 1'b1) begin
                    errors++; $display("FAIL bounce_latency: load_A=%b at cycle %0d required 1", load_A, i);
                end
            end
            if (load_A === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 1) begin
            errors++; $display("FAIL bounce_once: load_A count=%0d required 1", cnt);
        end
        enter = 1'b0;
        repeat (GAP) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_full_sequence();
        test_latency();
        test_undo();
        test_simultaneous();
        test_reset_mid();
`ifdef SEQ_DEBOUNCE_EN
        test_bounce();
`endif
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_drained: %0d expected strobes outstanding required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached required completion");
        $fatal(1, "watchdog");
    end

endmodule
